prog_loader: RTL and testbench

- Writer-side counterpart to the fetch path; fills instruction memory before the core runs.
- Receives a framed byte stream over a valid/ready interface.
- Assembles big-endian 16-bit words and writes them to consecutive memory addresses through the memory write port (en_write/addr/data_in).
- On a complete, valid frame, pulses run to start the fetch unit. Holds the core off (hold_core) while loading.

---
 rtl/prog_loader_if.sv | 20 ++
 rtl/prog_loader.sv | 160 ++++++++++++++++
 tb/tb_prog_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream intake and instruction-memory write port used by prog_loader.
// The loader side uses modport slave; the stream source / memory side uses master.
interface prog_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;

    modport master (
        output rx_valid, rx_byte,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_byte,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (SYNC, count hi/lo, big-endian
// data words), writes the words to consecutive instruction-memory addresses
// starting at BASE_ADDR, holds the core while loading and pulses run after a
// good frame. Optional macro CHECKSUM_EN adds a trailing 8-bit modular-sum
// checksum byte that must match before run is pulsed.
module prog_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 256,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus,
    output logic         hold_core,
    output logic         run,
    output logic         load_err,
    output logic [15:0]  words_loaded
);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, DONE, ERR, CHK
    } state_t;

    // State entered once the last word (or a zero count) has been handled.
`ifdef CHECKSUM_EN
    localparam state_t TAIL = CHK;
`else
    localparam state_t TAIL = DONE;
`endif

    localparam logic [31:0] MAX_U = MAX_WORDS;

    state_t      state_q, state_d;
    logic        rdy_q, rdy_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] words_q, words_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic        err_q, err_d;
    logic        take;
    logic [31:0] len_full;
`ifdef CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    assign take     = bus.rx_valid && rdy_q;
    assign len_full = {16'd0, cnt_q[15:8], bus.rx_byte};

    assign bus.rx_ready  = rdy_q;
    assign bus.mem_we    = (state_q == WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign hold_core     = (state_q != IDLE) && (state_q != ERR);
    assign run           = (state_q == DONE);
    assign load_err      = err_q;
    assign words_loaded  = words_q;

    // Next-state and datapath update for the frame parser.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        words_d = words_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (take && bus.rx_byte == SYNC_BYTE) begin
                state_d = LEN_HI;
                err_d   = 1'b0;
                words_d = 16'd0;
            end
            LEN_HI: if (take) begin
                cnt_d[15:8] = bus.rx_byte;
                state_d     = LEN_LO;
            end
            LEN_LO: if (take) begin
                cnt_d[7:0] = bus.rx_byte;
                if (len_full > MAX_U) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (len_full == 32'd0) begin
                    state_d = TAIL;
                end else begin
                    state_d = DAT_HI;
                end
            end
            DAT_HI: if (take) begin
                hi_d    = bus.rx_byte;
                state_d = DAT_LO;
            end
            DAT_LO: if (take) begin
                addr_d  = BASE_ADDR + words_q;
                wdata_d = {hi_q, bus.rx_byte};
                state_d = WRITE;
            end
            WRITE: begin
                words_d = words_q + 16'd1;
                state_d = (words_q + 16'd1 < cnt_q) ? DAT_HI : TAIL;
            end
`ifdef CHECKSUM_EN
            CHK: if (take) begin
                if (bus.rx_byte == sum_q) begin
                    state_d = DONE;
                end else begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
`endif
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Ready is registered so it is low during reset and rises one clock later.
        rdy_d = !(state_d inside {WRITE, DONE, ERR});
    end

    // Parser state, handshake and write-port registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            words_q <= 16'd0;
            cnt_q   <= 16'd0;
            hi_q    <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            words_q <= words_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end

`ifdef CHECKSUM_EN
    // Running sum of every byte after SYNC that belongs to the frame body.
    always_comb begin
        sum_d = sum_q;
        if (take && state_q == IDLE && bus.rx_byte == SYNC_BYTE)
            sum_d = 8'd0;
        else if (take && state_q inside {LEN_HI, LEN_LO, DAT_HI, DAT_LO})
            sum_d = sum_q + bus.rx_byte;
    end

    // Checksum accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sum_q <= 8'd0;
        else       sum_q <= sum_d;
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: frames are generated from a count and a
// word list, and the expected writes / run / error are derived from the frame
// rules directly. Two instances cover BASE_ADDR=0/MAX=256 and BASE_ADDR=FFFF/MAX=4.
module tb_prog_loader;

`ifdef CHECKSUM_EN
    localparam bit CK_ON = 1'b1;
`else
    localparam bit CK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prog_loader_if if0 ();
    prog_loader_if if1 ();

    logic        hold0, run0, err0, hold1, run1, err1;
    logic [15:0] wl0, wl1;

    prog_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256), .SYNC_BYTE(8'hA5)) dut0 (
        .clk(clk), .reset(reset), .bus(if0),
        .hold_core(hold0), .run(run0), .load_err(err0), .words_loaded(wl0)
    );

    prog_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(4), .SYNC_BYTE(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .bus(if1),
        .hold_core(hold1), .run(run1), .load_err(err1), .words_loaded(wl1)
    );

    logic       sel;
    logic       drv_valid;
    logic [7:0] drv_byte;

    assign if0.rx_valid = drv_valid && !sel;
    assign if0.rx_byte  = drv_byte;
    assign if1.rx_valid = drv_valid && sel;
    assign if1.rx_byte  = drv_byte;

    logic        sm_we, sm_rdy, sm_hold, sm_run, sm_err;
    logic [15:0] sm_addr, sm_data, sm_words;
    assign sm_we    = sel ? if1.mem_we    : if0.mem_we;
    assign sm_rdy   = sel ? if1.rx_ready  : if0.rx_ready;
    assign sm_addr  = sel ? if1.mem_addr  : if0.mem_addr;
    assign sm_data  = sel ? if1.mem_wdata : if0.mem_wdata;
    assign sm_hold  = sel ? hold1 : hold0;
    assign sm_run   = sel ? run1  : run0;
    assign sm_err   = sel ? err1  : err0;
    assign sm_words = sel ? wl1   : wl0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    logic [31:0] obs_wr[$];
    int          run_cnt = 0;
    logic [15:0] fixed_words[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (sm_we) begin
                obs_wr.push_back({sm_addr, sm_data});
                chk("rdy_in_write", {31'd0, sm_rdy}, 32'd0);
                chk("hold_in_write", {31'd0, sm_hold}, 32'd1);
            end
            if (sm_run) begin
                run_cnt++;
                chk("hold_at_run", {31'd0, sm_hold}, 32'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        for (int i = 0; i < gap; i++) @(negedge clk);
        @(negedge clk);
        drv_valid = 1'b1;
        drv_byte  = b;
        guard     = 0;
        while (!sm_rdy) begin
            @(negedge clk);
            guard++;
            if (guard > 40) begin
                chk("ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1 drv_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rdy"},   {31'd0, sm_rdy},  32'd0);
        chk({tag, "_we"},    {31'd0, sm_we},   32'd0);
        chk({tag, "_addr"},  {16'd0, sm_addr}, 32'd0);
        chk({tag, "_wdata"}, {16'd0, sm_data}, 32'd0);
        chk({tag, "_hold"},  {31'd0, sm_hold}, 32'd0);
        chk({tag, "_run"},   {31'd0, sm_run},  32'd0);
        chk({tag, "_err"},   {31'd0, sm_err},  32'd0);
        chk({tag, "_words"}, {16'd0, sm_words}, 32'd0);
    endtask

    // Build one frame, predict its outcome from the frame rules, send it, compare.
    task automatic run_frame(input int junk, input int cnt, input bit bad_ck, input int gap_mode);
        logic [7:0]  bytes[$];
        logic [31:0] exp_wr[$];
        logic [15:0] base, c, w;
        logic [7:0]  b, sum;
        int          maxw, gap;
        bit          len_ok, exp_run;
        base = sel ? 16'hFFFF : 16'h0000;
        maxw = sel ? 4 : 256;
        c    = 16'(cnt);
        for (int i = 0; i < junk; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            bytes.push_back(b);
        end
        bytes.push_back(8'hA5);
        bytes.push_back(c[15:8]);
        bytes.push_back(c[7:0]);
        sum    = c[15:8] + c[7:0];
        len_ok = (cnt <= maxw);
        if (len_ok) begin
            for (int i = 0; i < cnt; i++) begin
                w = (i < fixed_words.size()) ? fixed_words[i] : 16'($urandom);
                bytes.push_back(w[15:8]);
                bytes.push_back(w[7:0]);
                sum = sum + w[15:8] + w[7:0];
                exp_wr.push_back({16'(base + 16'(i)), w});
            end
            if (CK_ON) bytes.push_back(sum + {7'd0, bad_ck});
        end
        exp_run = len_ok && !(CK_ON && bad_ck);

        obs_wr.delete();
        run_cnt = 0;
        foreach (bytes[i]) begin
            gap = (gap_mode == 2) ? $urandom_range(0, 2) : gap_mode;
            send_byte(bytes[i], gap);
        end
        repeat (6) @(negedge clk);

        chk("n_writes", obs_wr.size(), exp_wr.size());
        foreach (exp_wr[i]) begin
            if (i < obs_wr.size()) begin
                chk("wr_addr", {16'd0, obs_wr[i][31:16]}, {16'd0, exp_wr[i][31:16]});
                chk("wr_data", {16'd0, obs_wr[i][15:0]},  {16'd0, exp_wr[i][15:0]});
            end
        end
        chk("run_pulses", run_cnt, exp_run ? 32'd1 : 32'd0);
        chk("load_err", {31'd0, sm_err}, {31'd0, !exp_run});
        chk("words_loaded", {16'd0, sm_words}, len_ok ? {16'd0, c} : 32'd0);
        chk("hold_end", {31'd0, sm_hold}, 32'd0);
        chk("rdy_end", {31'd0, sm_rdy}, 32'd1);
    endtask

    initial begin
        sel       = 1'b0;
        drv_valid = 1'b0;
        drv_byte  = 8'h00;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("rst0");
        sel = 1'b1;
        #1 check_reset_vals("rst1");
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", {31'd0, sm_rdy}, 32'd1);

        // Directed frames on the BASE=0 / MAX=256 instance.
        fixed_words = '{16'h1234, 16'hABCD};
        run_frame(0, 2, 1'b0, 0);
        fixed_words.delete();
        run_frame(2, 0, 1'b0, 0);
        run_frame(0, 257, 1'b0, 0);
        run_frame(0, 0, 1'b0, 0);
        fixed_words = '{16'h1234};
        run_frame(0, 1, 1'b0, 0);
        run_frame(0, 1, 1'b1, 0);
        fixed_words = '{16'hBEEF};
        run_frame(0, 1, 1'b0, 1);
        fixed_words = '{16'h00A5, 16'hA5A5};
        run_frame(1, 2, 1'b0, 0);
        fixed_words.delete();
        run_frame(0, 256, 1'b0, 2);
        for (int k = 0; k < 8; k++)
            run_frame($urandom_range(0, 3), $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 2));

        // BASE=FFFF / MAX=4 instance: address wrap and count limit.
        @(negedge clk);
        sel = 1'b1;
        fixed_words = '{16'h0001, 16'h0002};
        run_frame(0, 2, 1'b0, 0);
        fixed_words.delete();
        run_frame(0, 5, 1'b0, 0);
        run_frame(0, 4, 1'b0, 2);
        for (int k = 0; k < 6; k++)
            run_frame($urandom_range(0, 2), $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 2));

        // Reset mid-frame aborts the load.
        @(negedge clk);
        sel = 1'b0;
        obs_wr.delete();
        run_cnt = 0;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals("midrst");
        chk("midrst_one_write", obs_wr.size(), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_no_run", run_cnt, 32'd0);
        chk("midrst_hold", {31'd0, sm_hold}, 32'd0);
        chk("midrst_rdy", {31'd0, sm_rdy}, 32'd1);
        run_frame(0, 3, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
